// File: rtl/cal_average_fifo_ctrl.sv
// FIFO controller for the 128x32 pipelined USRAM buffer in the calibrator averaging path.
// Owns pointers, occupancy and sticky error flags; aligns RVALID with the RAM read latency.
module cal_average_fifo_ctrl #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 128,
    parameter int unsigned AW           = 7,
    parameter int unsigned RD_LATENCY   = 2,
    parameter int unsigned AFULL_THRESH = 120
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             CLR_ERR,
    input  logic             WE,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             RE,
    output logic [WIDTH-1:0] RDATA,
    output logic             RVALID,
    output logic             FULL,
    output logic             EMPTY,
    output logic             AFULL,
    output logic [AW:0]      COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW,
    output logic             RAM_WEN,
    output logic [AW-1:0]    RAM_WADDR,
    output logic [WIDTH-1:0] RAM_WDATA,
    output logic             RAM_REN,
    output logic [AW-1:0]    RAM_RADDR,
    input  logic [WIDTH-1:0] RAM_RDATA
);

    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [RD_LATENCY-1:0] r_vld_pipe;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [AW-1:0]         w_wr_ptr_nxt;
    logic [AW-1:0]         w_rd_ptr_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic [RD_LATENCY-1:0] w_vld_nxt;
    logic                  w_overflow_nxt;
    logic                  w_underflow_nxt;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Accepts are gated by FLUSH and by RESET so the RAM is never touched while clearing.
    assign w_wr_acc = WE & ~w_full  & ~FLUSH & ~RESET;
    assign w_rd_acc = RE & ~w_empty & ~FLUSH & ~RESET;

    always_comb begin
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_count_nxt     = r_count;
        w_vld_nxt       = '0;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;

        if (FLUSH) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + AW'(1);
            if (w_rd_acc) w_rd_ptr_nxt = r_rd_ptr + AW'(1);
            if (w_wr_acc && !w_rd_acc)      w_count_nxt = r_count + CW'(1);
            else if (w_rd_acc && !w_wr_acc) w_count_nxt = r_count - CW'(1);

            for (int unsigned i = RD_LATENCY - 1; i > 0; i--) begin
                w_vld_nxt[i] = r_vld_pipe[i-1];
            end
            w_vld_nxt[0] = w_rd_acc;

            // A fresh error beats a same-cycle clear.
            if (WE && w_full)   w_overflow_nxt  = 1'b1;
            else if (CLR_ERR)   w_overflow_nxt  = 1'b0;
            if (RE && w_empty)  w_underflow_nxt = 1'b1;
            else if (CLR_ERR)   w_underflow_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_vld_pipe  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_vld_pipe  <= w_vld_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    assign RAM_WEN   = w_wr_acc;
    assign RAM_WADDR = r_wr_ptr;
    assign RAM_WDATA = WDATA;
    assign RAM_REN   = w_rd_acc;
    assign RAM_RADDR = r_rd_ptr;

    assign RDATA     = RAM_RDATA;
    assign RVALID    = r_vld_pipe[RD_LATENCY-1];
    assign FULL      = w_full;
    assign EMPTY     = w_empty;
    assign AFULL     = (r_count >= CW'(AFULL_THRESH));
    assign COUNT     = r_count;
    assign OVERFLOW  = r_overflow;
    assign UNDERFLOW = r_underflow;

endmodule

// File: tb/tb_cal_average_fifo_ctrl.sv
// Self-checking bench for cal_average_fifo_ctrl with a 2-cycle pipelined RAM model.
// A queue-based FIFO model predicts accepts and flags; a scoreboard checks read data and timing.
module tb_cal_average_fifo_ctrl;

    localparam int DEPTH = 128;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        FLUSH = 1'b0;
    logic        CLR_ERR = 1'b0;
    logic        WE = 1'b0;
    logic        RE = 1'b0;
    logic [31:0] WDATA = '0;
    logic [31:0] RDATA;
    logic        RVALID, FULL, EMPTY, AFULL, OVERFLOW, UNDERFLOW;
    logic [7:0]  COUNT;
    logic        RAM_WEN, RAM_REN;
    logic [6:0]  RAM_WADDR, RAM_RADDR;
    logic [31:0] RAM_WDATA, RAM_RDATA;

    cal_average_fifo_ctrl dut (
        .CLOCK(CLOCK), .RESET(RESET), .FLUSH(FLUSH), .CLR_ERR(CLR_ERR),
        .WE(WE), .WDATA(WDATA), .RE(RE), .RDATA(RDATA), .RVALID(RVALID),
        .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL), .COUNT(COUNT),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
        .RAM_WEN(RAM_WEN), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA),
        .RAM_REN(RAM_REN), .RAM_RADDR(RAM_RADDR), .RAM_RDATA(RAM_RDATA)
    );

    always #5 CLOCK = ~CLOCK;

    // Pipelined RAM: registered read address, then registered data.
    logic [31:0] mem [DEPTH];
    logic [6:0]  raddr_q = '0;
    logic [31:0] rdata_q = '0;
    always @(posedge CLOCK) begin
        if (RAM_WEN) mem[RAM_WADDR] <= RAM_WDATA;
        if (RAM_REN) raddr_q <= RAM_RADDR;
        rdata_q <= mem[raddr_q];
    end
    assign RAM_RDATA = rdata_q;

    typedef struct { logic [31:0] d; int c; } sb_t;
    typedef struct {
        logic we, re, fl, clr;
        logic [31:0] wd;
        int cnt;
        logic emp, ovf, udf;
    } vec_t;

    sb_t         exp_q[$];
    logic [31:0] mq[$];
    int          wptr_m = 0, rptr_m = 0;
    logic        ovf_m = 1'b0, udf_m = 1'b0;
    int          cyc_n = 0;
    int          n_cmp = 0, n_err = 0;
    vec_t        tbl[10];

    always @(posedge CLOCK) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Scoreboard consumer: every RVALID must match the oldest pending read in data and cycle.
    always @(negedge CLOCK) begin
        if (!RESET && RVALID) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", 32'(RVALID), 32'h0);
            end else begin
                sb_t e;
                e = exp_q.pop_front();
                chk("rdata", RDATA, e.d);
                chk("rvalid_cycle", 32'(cyc_n), 32'(e.c));
            end
        end
    end

    task automatic cyc(input logic we, input logic re, input logic fl, input logic clr,
                       input logic [31:0] wd);
        logic full_m, empty_m, wacc, racc;
        @(negedge CLOCK);
        #1;
        WE = we; RE = re; FLUSH = fl; CLR_ERR = clr; WDATA = wd;
        full_m  = (mq.size() == DEPTH);
        empty_m = (mq.size() == 0);
        wacc = we && !full_m && !fl;
        racc = re && !empty_m && !fl;
        #1;
        chk("ram_wen", 32'(RAM_WEN), 32'(wacc));
        chk("ram_ren", 32'(RAM_REN), 32'(racc));
        if (wacc) chk("ram_waddr", 32'(RAM_WADDR), 32'(wptr_m));
        if (racc) chk("ram_raddr", 32'(RAM_RADDR), 32'(rptr_m));
        if (fl) begin
            mq.delete();
            exp_q.delete();
            wptr_m = 0;
            rptr_m = 0;
        end else begin
            if (racc) begin
                sb_t e;
                e.d = mq.pop_front();
                e.c = cyc_n + 2;
                exp_q.push_back(e);
                rptr_m = (rptr_m + 1) % DEPTH;
            end
            if (wacc) begin
                mq.push_back(wd);
                wptr_m = (wptr_m + 1) % DEPTH;
            end
            if (we && full_m) ovf_m = 1'b1; else if (clr) ovf_m = 1'b0;
            if (re && empty_m) udf_m = 1'b1; else if (clr) udf_m = 1'b0;
        end
        @(posedge CLOCK);
        #1;
        chk("count", 32'(COUNT), 32'(mq.size()));
        chk("full", 32'(FULL), 32'(mq.size() == DEPTH));
        chk("empty", 32'(EMPTY), 32'(mq.size() == 0));
        chk("afull", 32'(AFULL), 32'(mq.size() >= 120));
        chk("overflow", 32'(OVERFLOW), 32'(ovf_m));
        chk("underflow", 32'(UNDERFLOW), 32'(udf_m));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h11, 1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h22, 2, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h33, 1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 0, 1'b1, 1'b0, 1'b0};

        // Reset values
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rst_count", 32'(COUNT), 32'h0);
        chk("rst_empty", 32'(EMPTY), 32'h1);
        chk("rst_full", 32'(FULL), 32'h0);
        chk("rst_afull", 32'(AFULL), 32'h0);
        chk("rst_rvalid", 32'(RVALID), 32'h0);
        chk("rst_flags", {30'h0, OVERFLOW, UNDERFLOW}, 32'h0);
        @(negedge CLOCK);
        RESET = 1'b0;

        // Hand-expected vectors: simultaneous access on empty, error clear priority, flush
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].we, tbl[i].re, tbl[i].fl, tbl[i].clr, tbl[i].wd);
            chk("tbl_count", 32'(COUNT), 32'(tbl[i].cnt));
            chk("tbl_empty", 32'(EMPTY), 32'(tbl[i].emp));
            chk("tbl_ovf", 32'(OVERFLOW), 32'(tbl[i].ovf));
            chk("tbl_udf", 32'(UNDERFLOW), 32'(tbl[i].udf));
        end
        idle(3);

        // Five words then five back-to-back reads
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hA0 + 32'(i));
        chk("five_count", 32'(COUNT), 32'd5);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(3);
        chk("five_empty", 32'(EMPTY), 32'h1);

        // Fill to full, overflow, clear
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h1000 + 32'(i));
        chk("fill_full", 32'(FULL), 32'h1);
        chk("fill_count", 32'(COUNT), 32'd128);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD);
        chk("ovf_set", 32'(OVERFLOW), 32'h1);
        chk("ovf_count", 32'(COUNT), 32'd128);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("ovf_clr", 32'(OVERFLOW), 32'h0);

        // Simultaneous access while full, then drain
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h2000 + 32'(i));
        chk("repl_count", 32'(COUNT), 32'd127);
        chk("repl_ovf", 32'(OVERFLOW), 32'h1);
        for (int i = 0; i < 128; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        idle(3);

        // 300-word stream through the pointer wrap
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000);
        for (int i = 1; i < 300; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h3000 + 32'(i));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(3);

        // Flush drops reads still in flight
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h4000 + 32'(i));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("flush_count", 32'(COUNT), 32'h0);
        chk("flush_empty", 32'(EMPTY), 32'h1);
        idle(4);

        // Asynchronous reset mid-stream
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h5000 + 32'(i));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h5004);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge CLOCK);
        #2;
        WE = 1'b1; RE = 1'b1; RESET = 1'b1;
        #1;
        chk("arst_count", 32'(COUNT), 32'h0);
        chk("arst_rvalid", 32'(RVALID), 32'h0);
        chk("arst_empty", 32'(EMPTY), 32'h1);
        chk("arst_udf", 32'(UNDERFLOW), 32'h0);
        chk("arst_ram_en", {30'h0, RAM_WEN, RAM_REN}, 32'h0);
        mq.delete();
        exp_q.delete();
        wptr_m = 0; rptr_m = 0; ovf_m = 1'b0; udf_m = 1'b0;
        @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0; WE = 1'b0; RE = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h6000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(4);

        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
